// File: rtl/demo_qsys_led_pkg.sv
// Register map and STATUS bit positions shared by the LED/PIO output controller.
package demo_qsys_led_pkg;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_SET        = 3'd1;
  localparam logic [2:0] ADDR_CLEAR      = 3'd2;
  localparam logic [2:0] ADDR_BLINK_MASK = 3'd3;
  localparam logic [2:0] ADDR_PERIOD     = 3'd4;
  localparam logic [2:0] ADDR_STATUS     = 3'd5;

  localparam int unsigned STATUS_PHASE_BIT = 0;
  localparam int unsigned STATUS_EN_BIT    = 1;

endpackage

// File: rtl/demo_qsys_led_output_ctrl_if.sv
// Avalon-MM slave bus of the LED controller: zero wait states, readLatency 0, no backpressure.
interface demo_qsys_led_output_ctrl_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/demo_qsys_led_blink_timer.sv
// Blink phase generator: phase toggles every `period` cycles, period 0 holds it low.
// A load restarts the count from the presented period with phase cleared, in the same edge.
module demo_qsys_led_blink_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                load,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] reload;

  assign reload = (period == '0) ? '0 : period - PERIOD_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (load) begin
      cnt   <= reload;
      phase <= 1'b0;
    end else if (period == '0) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == '0) begin
      cnt   <= reload;
      phase <= ~phase;
    end else begin
      cnt <= cnt - PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/demo_qsys_led_output_ctrl.sv
// LED/PIO output register file with atomic set/clear and hardware blink.
// Writes land on the sampling edge; reads and out_port are combinational; never stalls the bus.
module demo_qsys_led_output_ctrl
  import demo_qsys_led_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PERIOD_W    = 24
) (
  input  logic                           clk,
  input  logic                           reset_n,
  demo_qsys_led_output_ctrl_if.slave     bus,
  output logic [WIDTH-1:0]               out_port
);

  logic [WIDTH-1:0]    data_q;
  logic [WIDTH-1:0]    mask_q;
  logic [PERIOD_W-1:0] period_q;
  logic [WIDTH-1:0]    wd_w;
  logic [PERIOD_W-1:0] wd_p;
  logic                wr;
  logic                period_load;
  logic [PERIOD_W-1:0] timer_period;
  logic                phase;
  logic [31:0]         rd;
  logic                unused_wdata;

  assign wr          = bus.chipselect && !bus.write_n;
  assign wd_w        = bus.writedata[WIDTH-1:0];
  assign wd_p        = bus.writedata[PERIOD_W-1:0];
  assign period_load = wr && (bus.address == ADDR_PERIOD);
  // The timer must see the incoming period on the loading edge, not the stale register.
  assign timer_period = period_load ? wd_p : period_q;
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      period_q <= '0;
    end else if (wr) begin
      case (bus.address)
        ADDR_DATA:       data_q   <= wd_w;
        ADDR_SET:        data_q   <= data_q | wd_w;
        ADDR_CLEAR:      data_q   <= data_q & ~wd_w;
        ADDR_BLINK_MASK: mask_q   <= wd_w;
        ADDR_PERIOD:     period_q <= wd_p;
        default: ;
      endcase
    end
  end

  demo_qsys_led_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_blink_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (timer_period),
    .load    (period_load),
    .phase   (phase)
  );

  always_comb begin
    rd = '0;
    case (bus.address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR: rd = 32'(data_q);
      ADDR_BLINK_MASK:                 rd = 32'(mask_q);
      ADDR_PERIOD:                     rd = 32'(period_q);
      ADDR_STATUS: begin
        rd[STATUS_PHASE_BIT] = phase;
        rd[STATUS_EN_BIT]    = (period_q != '0);
      end
      default: rd = '0;
    endcase
  end

  assign bus.readdata = rd;
  assign out_port     = data_q ^ (mask_q & {WIDTH{phase}});

endmodule

// File: doc/demo_qsys_led_output_ctrl.md
# demo_qsys_led_output_ctrl

Parametrised Avalon-MM LED/PIO output controller for the HPS demo Qsys system. It succeeds the fixed 4-bit single-register LED output. It adds a configurable width and atomic bit set/clear registers. A per-bit hardware blink engine with a programmable half-period lets the HPS flash LEDs without software polling. It is a zero-wait-state Avalon slave with read latency 0, sitting between the lightweight HPS-to-FPGA bridge and the board LED pins.

## Interface
- WIDTH, 4: number of output bits, 1..32.
- RESET_VALUE, 0: DATA register value after reset, WIDTH bits.
- PERIOD_W, 24: width of the PERIOD register and the blink counter, 1..32.
- clk  in  1  system clock. Reset is reset_n, asynchronous, active-low; clock is clk.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word register address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above the register width are ignored.
- readdata  out  32  combinational read data, zero-extended.
- out_port  out  WIDTH  LED/pin output.

## Operation
- Register map (word addresses):
  - 0 DATA rw: base output pattern.
  - 1 SET wo: DATA |= writedata; a read returns DATA.
  - 2 CLEAR wo: DATA &= ~writedata; a read returns DATA.
  - 3 BLINK_MASK rw: WIDTH bits; a 1 means that bit blinks.
  - 4 PERIOD rw: PERIOD_W bits; blink half-period in clk cycles; 0 disables blinking.
  - 5 STATUS ro: bit0 = blink phase, bit1 = blink enabled (PERIOD != 0).
  - 6, 7: read 0; writes ignored.
- A write occurs when chipselect=1 and write_n=0. Only one register is written per cycle, so DATA updates never collide.
- out_port = DATA ^ (BLINK_MASK & {WIDTH{phase}}). This is combinational from registers, with no extra pipeline stage.
- Blink engine: down-counter cnt (PERIOD_W bits) and phase bit.
  - PERIOD = 0: cnt and phase are held at 0.
  - PERIOD = P >= 1, cnt = 0: phase toggles and cnt reloads P-1. Otherwise cnt decrements. Result: phase toggles exactly every P cycles.
  - Write to PERIOD: cnt loads new P-1 (or 0 if P=0) and phase clears to 0, in the same edge. This restart has priority over the normal count/toggle.
  - Write to BLINK_MASK does not disturb cnt or phase. A bit newly set in the mask blinks at the current phase immediately.
- Reset values:
  - DATA = RESET_VALUE
  - BLINK_MASK = 0, PERIOD = 0, cnt = 0, phase = 0
  - out_port = RESET_VALUE
  - readdata follows the address decode; it is 0 whenever no valid register is addressed.
- Reset asserted mid-blink forces all state to the reset values asynchronously. Counting resumes only after PERIOD is rewritten.

## Timing
- Write takes effect at the clk edge where it is sampled. out_port reflects it in the following cycle (0-cycle register-to-pin latency).
- Read is combinational (readLatency 0). A read in the same cycle as a write to the same register returns the pre-write value.
- Blink toggles occur at edges P, 2P, 3P, … after the edge that wrote PERIOD=P.
- PERIOD=1 gives a phase toggle every cycle (out_port blink period 2 cycles).

## Structure
- Package demo_qsys_led_pkg holds:
  - register address constants ADDR_DATA, ADDR_SET, ADDR_CLEAR, ADDR_BLINK_MASK, ADDR_PERIOD, ADDR_STATUS;
  - STATUS bit index constants.
- One sub-module, demo_qsys_led_blink_timer:
  - parameter PERIOD_W;
  - inputs period, load;
  - output phase;
  - contains cnt and the toggle logic.
- The top level contains the register file, read mux and output XOR.

## Test plan
- Reset with WIDTH=4, RESET_VALUE=4'hA -> out_port=4'hA, readdata at addr 0 = 32'hA, STATUS=0.
- Write DATA=4'h3, SET=4'h8, CLEAR=4'h1 -> DATA reads 4'hA, out_port=4'hA after the last write.
- DATA=4'h0, BLINK_MASK=4'h5, PERIOD=3 -> out_port = 4'h0 for 3 cycles, then 4'h5 for 3 cycles, repeating; STATUS bit1=1.
- While blinking with phase=1, write PERIOD=0 -> next cycle phase=0, out_port=DATA, STATUS=0, and it stays so for 100 cycles.
- Mid-blink, assert reset_n=0 for 1 cycle, asynchronously between edges -> out_port immediately = RESET_VALUE, PERIOD reads 0.
- WIDTH=32, write DATA=32'hFFFF_FFFF and read address 6 -> readdata=0, DATA unchanged, and the write to address 7 has no effect.
